// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_sequencer
// Purpose  : Streams weights/biases/input into one conv engine, starts it,
//            forwards its results and checks the output count.
// Revision : 1.0 - initial release
// ============================================================================
module conv_layer_sequencer #(
  parameter int INPUT_CHANNELS  = 64,
  parameter int OUTPUT_CHANNELS = 128,
  parameter int KERNEL_SIZE     = 3,
  parameter int INPUT_WIDTH     = 30,
  parameter int INPUT_HEIGHT    = 30,
  localparam int N_IN  = INPUT_CHANNELS * INPUT_HEIGHT * INPUT_WIDTH,
  localparam int N_W   = OUTPUT_CHANNELS * INPUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
  localparam int N_B   = OUTPUT_CHANNELS,
  localparam int N_OUT = OUTPUT_CHANNELS * (INPUT_HEIGHT - KERNEL_SIZE + 1)
                         * (INPUT_WIDTH - KERNEL_SIZE + 1),
  localparam int IN_AW = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int W_AW  = (N_W  > 1) ? $clog2(N_W)  : 1,
  localparam int B_AW  = (N_B  > 1) ? $clog2(N_B)  : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_load_params,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             conv_start,
  input  logic             conv_done,
  output logic             conv_input_we,
  output logic [IN_AW-1:0] conv_input_addr,
  output logic [7:0]       conv_input_data,
  output logic             conv_weight_we,
  output logic [W_AW-1:0]  conv_weight_addr,
  output logic [7:0]       conv_weight_data,
  output logic             conv_bias_we,
  output logic [B_AW-1:0]  conv_bias_addr,
  output logic [31:0]      conv_bias_data,
  input  logic [7:0]       conv_result,
  input  logic             conv_valid,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             busy,
  output logic             layer_done,
  output logic             err_count,
  output logic             params_loaded
);

  localparam int CW_A = (IN_AW > W_AW) ? IN_AW : W_AW;
  localparam int CW   = (CW_A > B_AW) ? CW_A : B_AW;
  localparam int OCW  = $clog2(N_OUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    LOAD_I = 3'd3,
    START  = 3'd4,
    RUN    = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [OCW-1:0] out_cnt;
  logic           accept;
  logic           last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    last_beat = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (cfg_start)
          state_nxt = (cfg_load_params || !params_loaded) ? LOAD_W : LOAD_I;
      end
      LOAD_W: begin
        s_ready   = 1'b1;
        last_beat = (cnt == CW'(N_W - 1));
        if (s_valid && last_beat) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        s_ready   = 1'b1;
        last_beat = (cnt == CW'(N_B - 1));
        if (s_valid && last_beat) state_nxt = LOAD_I;
      end
      LOAD_I: begin
        s_ready   = 1'b1;
        last_beat = (cnt == CW'(N_IN - 1));
        if (s_valid && last_beat) state_nxt = START;
      end
      START:   state_nxt = RUN;
      RUN:     if (conv_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt              <= '0;
      out_cnt          <= '0;
      conv_start       <= 1'b0;
      conv_input_we    <= 1'b0;
      conv_input_addr  <= '0;
      conv_input_data  <= '0;
      conv_weight_we   <= 1'b0;
      conv_weight_addr <= '0;
      conv_weight_data <= '0;
      conv_bias_we     <= 1'b0;
      conv_bias_addr   <= '0;
      conv_bias_data   <= '0;
      m_data           <= '0;
      m_valid          <= 1'b0;
      m_last           <= 1'b0;
      layer_done       <= 1'b0;
      err_count        <= 1'b0;
      params_loaded    <= 1'b0;
    end else begin
      conv_start     <= 1'b0;
      conv_input_we  <= 1'b0;
      conv_weight_we <= 1'b0;
      conv_bias_we   <= 1'b0;
      m_valid        <= 1'b0;
      m_last         <= 1'b0;
      layer_done     <= 1'b0;
      // The beat index wraps to zero on the last beat so each load state starts at 0
      if (accept) cnt <= last_beat ? '0 : cnt + CW'(1);
      case (state)
        IDLE: begin
          if (cfg_start) begin
            cnt       <= '0;
            out_cnt   <= '0;
            err_count <= 1'b0;
            if (cfg_load_params) params_loaded <= 1'b0;
          end
        end
        LOAD_W: begin
          if (accept) begin
            conv_weight_we   <= 1'b1;
            conv_weight_addr <= cnt[W_AW-1:0];
            conv_weight_data <= s_data[7:0];
          end
        end
        LOAD_B: begin
          if (accept) begin
            conv_bias_we   <= 1'b1;
            conv_bias_addr <= cnt[B_AW-1:0];
            conv_bias_data <= s_data;
            if (last_beat) params_loaded <= 1'b1;
          end
        end
        LOAD_I: begin
          if (accept) begin
            conv_input_we   <= 1'b1;
            conv_input_addr <= cnt[IN_AW-1:0];
            conv_input_data <= s_data[7:0];
          end
        end
        START: conv_start <= 1'b1;
        RUN: begin
          if (conv_valid) begin
            m_data  <= conv_result;
            m_valid <= 1'b1;
            m_last  <= (out_cnt == OCW'(N_OUT - 1));
            // Extra beats are still forwarded but flag a count error
            if (out_cnt == OCW'(N_OUT)) err_count <= 1'b1;
            else                        out_cnt   <= out_cnt + OCW'(1);
          end
        end
        DONE: begin
          if (out_cnt != OCW'(N_OUT)) err_count <= 1'b1;
          layer_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// Directed self-checking bench for conv_layer_sequencer with a small
// behavioural conv engine (IC=2, OC=2, K=3, 5x5 input).
module tb_conv_layer_sequencer;

  localparam int IC = 2, OC = 2, K = 3, IW = 5, IH = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_load_params = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        conv_start;
  logic        conv_done = 1'b0;
  logic        conv_input_we;
  logic [5:0]  conv_input_addr;
  logic [7:0]  conv_input_data;
  logic        conv_weight_we;
  logic [5:0]  conv_weight_addr;
  logic [7:0]  conv_weight_data;
  logic        conv_bias_we;
  logic [0:0]  conv_bias_addr;
  logic [31:0] conv_bias_data;
  logic [7:0]  conv_result = '0;
  logic        conv_valid = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid, m_last, busy, layer_done, err_count, params_loaded;

  conv_layer_sequencer #(
    .INPUT_CHANNELS(IC), .OUTPUT_CHANNELS(OC), .KERNEL_SIZE(K),
    .INPUT_WIDTH(IW), .INPUT_HEIGHT(IH)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_load_params(cfg_load_params),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .conv_start(conv_start), .conv_done(conv_done),
    .conv_input_we(conv_input_we), .conv_input_addr(conv_input_addr),
    .conv_input_data(conv_input_data),
    .conv_weight_we(conv_weight_we), .conv_weight_addr(conv_weight_addr),
    .conv_weight_data(conv_weight_data),
    .conv_bias_we(conv_bias_we), .conv_bias_addr(conv_bias_addr),
    .conv_bias_data(conv_bias_data),
    .conv_result(conv_result), .conv_valid(conv_valid),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .busy(busy),
    .layer_done(layer_done), .err_count(err_count), .params_loaded(params_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Engine model: after conv_start emit eng_n results, then done
  int eng_n = 18;
  bit eng_coinc = 1'b0;
  always begin
    @(negedge clk);
    if (conv_start) begin
      for (int i = 0; i < eng_n; i++) begin
        @(posedge clk); #1;
        conv_valid  = 1'b1;
        conv_result = 8'(i * 7 + 3);
        conv_done   = eng_coinc && (i == eng_n - 1);
      end
      @(posedge clk); #1;
      conv_valid = 1'b0;
      if (!eng_coinc) begin
        conv_done = 1'b1;
        @(posedge clk); #1;
      end
      conv_done = 1'b0;
    end
  end

  // Monitor: counts writes/results, checks addresses and data per run
  int w_wr, b_wr, i_wr, addr_err, data_err, start_cnt, start_cyc;
  int mcount, mlast_cnt, last_idx, ldone_cnt;
  int in_base = 0;
  always @(negedge clk) begin
    if (cfg_start) begin
      w_wr = 0; b_wr = 0; i_wr = 0; addr_err = 0; data_err = 0; start_cnt = 0;
      start_cyc = -1; mcount = 0; mlast_cnt = 0; last_idx = -1; ldone_cnt = 0;
    end else begin
      if (conv_weight_we) begin
        if (conv_weight_addr != 6'(w_wr)) addr_err++;
        if (conv_weight_data != 8'(w_wr)) data_err++;
        w_wr++;
      end
      if (conv_bias_we) begin
        if (conv_bias_addr != 1'(b_wr)) addr_err++;
        if (conv_bias_data != 32'hC0DE_0000 + 32'(36 + b_wr)) data_err++;
        b_wr++;
      end
      if (conv_input_we) begin
        if (conv_input_addr != 6'(i_wr)) addr_err++;
        if (conv_input_data != 8'(in_base + i_wr)) data_err++;
        i_wr++;
      end
      if (conv_start) begin start_cnt++; start_cyc = cyc; end
      if (m_valid) begin
        if (m_data != 8'(mcount * 7 + 3)) data_err++;
        if (m_last) begin mlast_cnt++; last_idx = mcount; end
        mcount++;
      end
      if (layer_done) ldone_cnt++;
    end
  end

  int last_acc_cyc = -100;

  task automatic feed(input int n, input bit toggle);
    int k = 0;
    int guard = 0;
    bit skip = 1'b0;
    while (k < n && guard < 4000) begin
      @(posedge clk); #1;
      if (toggle && skip) begin
        s_valid = 1'b0; skip = 1'b0;
      end else begin
        s_valid = 1'b1; s_data = 32'hC0DE_0000 + 32'(k); skip = toggle;
      end
      @(negedge clk);
      if (s_valid && s_ready) begin last_acc_cyc = cyc; k++; end
      guard++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    checks++;
    if (k !== n) begin
      failures++;
      $display("FAIL feed_beats: accepted=%0d required=%0d", k, n);
    end
  endtask

  task automatic do_run(input bit load, input int n_feed, input bit toggle,
                        input int en, input bit coinc);
    int guard = 0;
    eng_n = en; eng_coinc = coinc;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_load_params = load;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_load_params = 1'b0;
    feed(n_feed, toggle);
    while (ldone_cnt == 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (ldone_cnt == 0) begin
      failures++;
      $display("FAIL layer_done_timeout: seen=%0d required=1", ldone_cnt);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, s_ready, conv_start, m_valid, m_last, layer_done, err_count, params_loaded,
         conv_weight_we, conv_bias_we, conv_input_we} !== 11'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got=%b required=0", {busy, s_ready, conv_start, m_valid,
               m_last, layer_done, err_count, params_loaded, conv_weight_we, conv_bias_we,
               conv_input_we});
    end
    checks++;
    if (m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data: got=%h required=00", m_data); end
    rst = 1'b0;
  endtask

  task automatic test_first_run;
    in_base = 38;
    do_run(1'b0, 88, 1'b0, 18, 1'b0);
    checks++; if (w_wr !== 36) begin failures++; $display("FAIL first_w_writes: got=%0d required=36", w_wr); end
    checks++; if (b_wr !== 2)  begin failures++; $display("FAIL first_b_writes: got=%0d required=2", b_wr); end
    checks++; if (i_wr !== 50) begin failures++; $display("FAIL first_i_writes: got=%0d required=50", i_wr); end
    checks++; if (addr_err !== 0) begin failures++; $display("FAIL first_addr: errors=%0d required=0", addr_err); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL first_data: errors=%0d required=0", data_err); end
    checks++; if (start_cnt !== 1) begin failures++; $display("FAIL first_start_cnt: got=%0d required=1", start_cnt); end
    checks++;
    if (start_cyc !== last_acc_cyc + 2) begin
      failures++;
      $display("FAIL first_start_latency: got=%0d required=%0d", start_cyc - last_acc_cyc, 2);
    end
    checks++; if (mcount !== 18) begin failures++; $display("FAIL first_m_count: got=%0d required=18", mcount); end
    checks++; if (last_idx !== 17) begin failures++; $display("FAIL first_m_last_idx: got=%0d required=17", last_idx); end
    checks++; if (mlast_cnt !== 1) begin failures++; $display("FAIL first_m_last_cnt: got=%0d required=1", mlast_cnt); end
    checks++; if (err_count !== 1'b0) begin failures++; $display("FAIL first_err: got=%b required=0", err_count); end
    checks++; if (params_loaded !== 1'b1) begin failures++; $display("FAIL first_params_loaded: got=%b required=1", params_loaded); end
    repeat (2) @(negedge clk);
    checks++; if (ldone_cnt !== 1) begin failures++; $display("FAIL first_layer_done_pulse: got=%0d required=1", ldone_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL first_busy_idle: got=%b required=0", busy); end
  endtask

  task automatic test_second_run;
    in_base = 0;
    do_run(1'b0, 50, 1'b0, 18, 1'b0);
    checks++; if (w_wr + b_wr !== 0) begin failures++; $display("FAIL second_param_writes: got=%0d required=0", w_wr + b_wr); end
    checks++; if (i_wr !== 50) begin failures++; $display("FAIL second_i_writes: got=%0d required=50", i_wr); end
    checks++; if (addr_err + data_err !== 0) begin failures++; $display("FAIL second_addr_data: errors=%0d required=0", addr_err + data_err); end
    checks++; if (mcount !== 18) begin failures++; $display("FAIL second_m_count: got=%0d required=18", mcount); end
  endtask

  task automatic test_toggle_valid;
    in_base = 38;
    do_run(1'b1, 88, 1'b1, 18, 1'b0);
    checks++; if (w_wr !== 36) begin failures++; $display("FAIL toggle_w_writes: got=%0d required=36", w_wr); end
    checks++; if (addr_err !== 0) begin failures++; $display("FAIL toggle_addr: errors=%0d required=0", addr_err); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL toggle_data: errors=%0d required=0", data_err); end
    checks++; if (i_wr !== 50) begin failures++; $display("FAIL toggle_i_writes: got=%0d required=50", i_wr); end
  endtask

  task automatic test_short_output;
    in_base = 0;
    do_run(1'b0, 50, 1'b0, 17, 1'b0);
    checks++; if (err_count !== 1'b1) begin failures++; $display("FAIL short_err: got=%b required=1", err_count); end
    checks++; if (mcount !== 17) begin failures++; $display("FAIL short_m_count: got=%0d required=17", mcount); end
    checks++; if (mlast_cnt !== 0) begin failures++; $display("FAIL short_m_last_cnt: got=%0d required=0", mlast_cnt); end
  endtask

  task automatic test_long_output;
    in_base = 0;
    do_run(1'b0, 50, 1'b0, 19, 1'b0);
    checks++; if (err_count !== 1'b1) begin failures++; $display("FAIL long_err: got=%b required=1", err_count); end
    checks++; if (mcount !== 19) begin failures++; $display("FAIL long_m_count: got=%0d required=19", mcount); end
    checks++; if (mlast_cnt !== 1) begin failures++; $display("FAIL long_m_last_cnt: got=%0d required=1", mlast_cnt); end
    checks++; if (last_idx !== 17) begin failures++; $display("FAIL long_m_last_idx: got=%0d required=17", last_idx); end
  endtask

  task automatic test_coincident_done;
    in_base = 0;
    do_run(1'b0, 50, 1'b0, 18, 1'b1);
    checks++; if (err_count !== 1'b0) begin failures++; $display("FAIL coinc_err: got=%b required=0", err_count); end
    checks++; if (mcount !== 18) begin failures++; $display("FAIL coinc_m_count: got=%0d required=18", mcount); end
    checks++; if (last_idx !== 17) begin failures++; $display("FAIL coinc_m_last_idx: got=%0d required=17", last_idx); end
  endtask

  task automatic test_reset_mid_load;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_load_params = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_load_params = 1'b0;
    feed(58, 1'b0);
    checks++; if (params_loaded !== 1'b1) begin failures++; $display("FAIL midrst_pre_params: got=%b required=1", params_loaded); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, s_ready, params_loaded, conv_input_we} !== 4'b0) begin
      failures++;
      $display("FAIL midrst_async_clear: got=%b required=0000", {busy, s_ready, params_loaded, conv_input_we});
    end
    @(negedge clk);
    rst = 1'b0;
    in_base = 38;
    do_run(1'b0, 88, 1'b0, 18, 1'b0);
    checks++; if (w_wr !== 36) begin failures++; $display("FAIL midrst_reload_w: got=%0d required=36", w_wr); end
    checks++; if (i_wr !== 50) begin failures++; $display("FAIL midrst_i_writes: got=%0d required=50", i_wr); end
    checks++; if (params_loaded !== 1'b1) begin failures++; $display("FAIL midrst_params: got=%b required=1", params_loaded); end
  endtask

  initial begin
    test_reset;
    test_first_run;
    test_second_run;
    test_toggle_valid;
    test_short_output;
    test_long_output;
    test_coincident_done;
    test_reset_mid_load;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Sequences one quantized conv+ReLU layer engine (byte-wide input/weight write ports, 32-bit bias write port, start/done, conv_result/conv_valid output).
- Streams parameters and the input feature map from an upstream valid/ready source into the engine's memories, pulses start, then collects and forwards results downstream.
- Checks the output count and reports status.
- Sits between the DMA/stream fabric and the conv engine; one instance per engine.

Parameters:
- INPUT_CHANNELS, 64, engine input channels
- OUTPUT_CHANNELS, 128, engine output channels
- KERNEL_SIZE, 3, square kernel size
- INPUT_WIDTH, 30, padded input width
- INPUT_HEIGHT, 30, padded input height
- Derived, not overridable:
  - N_IN = IC*IH*IW
  - N_W = OC*IC*K*K
  - N_B = OC
  - N_OUT = OC*(IH-K+1)*(IW-K+1)

Ports:
- clk  in  1  sole clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- cfg_start  in  1  request one layer run; sampled only in IDLE
- cfg_load_params  in  1  sampled with cfg_start; 1 = reload weights+biases before input
- s_data  in  32  load stream; bits[7:0] used for input/weights, all 32 for bias
- s_valid  in  1  load stream valid
- s_ready  out  1  load stream ready
- conv_start  out  1  one-cycle start pulse to engine
- conv_done  in  1  engine done
- conv_input_we/addr[clog2(N_IN)]/data[8]  out  engine input write port
- conv_weight_we/addr[clog2(N_W)]/data[8]  out  engine weight write port
- conv_bias_we/addr[clog2(N_B)]/data[32]  out  engine bias write port
- conv_result  in  8  engine result
- conv_valid  in  1  engine result valid
- m_data  out  8  forwarded result (registered)
- m_valid  out  1  forwarded valid
- m_last  out  1  high with the N_OUT-th forwarded result
- busy  out  1  high in any state except IDLE
- layer_done  out  1  one-cycle pulse on entering IDLE from DONE
- err_count  out  1  sticky until next accepted cfg_start: output count != N_OUT at conv_done
- params_loaded  out  1  weights+biases valid in engine

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE, params_loaded=0. Reset mid-run aborts immediately; the engine is not notified.
- FSM states: IDLE, LOAD_W, LOAD_B, LOAD_I, START, RUN, DONE.
- IDLE + cfg_start:
  - If cfg_load_params=1 or params_loaded=0, go to LOAD_W; clear params_loaded.
  - Otherwise go to LOAD_I.
  - Clear err_count and the output counter.
- cfg_start outside IDLE is ignored.
- Load states:
  - s_ready=1 only in LOAD_W/LOAD_B/LOAD_I. Beat accepted when s_valid&s_ready.
  - Accepted beat → corresponding *_we=1 next cycle, addr = current beat index, data = registered s_data slice. One beat per cycle, no bubbles required.
  - LOAD_W → LOAD_B after beat N_W-1. LOAD_B → LOAD_I after beat N_B-1, and params_loaded is set then.
  - LOAD_I → START after beat N_IN-1.
  - Address counters restart at 0 on entering each load state.
  - s_valid low stalls the state with we=0.
- START: conv_start=1 for exactly one cycle, issued after the final write has been driven. Go to RUN.
- RUN:
  - Each conv_valid cycle: m_data<=conv_result, m_valid<=1 one cycle later; output counter increments.
  - m_last=1 when the counter equals N_OUT-1 at that beat.
  - The counter saturates at N_OUT. Beats beyond N_OUT are still forwarded with m_last=0 and set err_count.
  - No backpressure: downstream must accept every m_valid.
- conv_done in RUN → DONE.
  - A conv_valid in the same cycle as conv_done is counted and forwarded.
  - In DONE, err_count |= (count != N_OUT). Then go to IDLE with a layer_done pulse.
- Outside RUN, conv_valid is ignored (not forwarded, not counted) and conv_done is ignored.
- Latency: last input beat accepted at cycle t → last we at t+1 → conv_start at t+2.

Test Plan:
- Params IC=2, OC=2, K=3, IW=IH=5 (N_IN=50, N_W=36, N_B=2, N_OUT=18). Behavioural engine model: done after 18 valids.
- First run, cfg_load_params=0, continuous s_valid → 36 weight writes at addr 0..35, 2 bias writes, 50 input writes, conv_start exactly once 2 cycles after last input beat; 18 m_valid with m_last on 18th; layer_done; err_count=0; params_loaded=1.
- Second run, cfg_load_params=0 → no weight/bias writes, only 50 input writes; bias/weight we never asserted.
- s_valid toggled 1-0-1 during LOAD_W → writes only on accepted beats, addresses contiguous 0..35 with no skips/duplicates.
- Engine model emits 17 valids then done → err_count=1, layer_done pulses. Engine emits 19 → m_last only on 18th, err_count=1.
- Last conv_valid coincident with conv_done → counted, m_last=1, err_count=0.
- rst asserted mid LOAD_I (beat 20) → outputs 0 asynchronously, IDLE, params_loaded=0. Next cfg_start with cfg_load_params=0 reloads weights first.
